// File: rtl/eva_mem_wrap_p.sv
// Single-clock 1W/1R memory model with byte enables, RD_LAT-deep read pipeline, optional write
// forwarding, a one-word-per-cycle clear engine and a sticky error flag. No backpressure.
module eva_mem_wrap_p #(
  parameter int            DW       = 32,
  parameter int            DEPTH    = 64,
  parameter int            RD_LAT   = 1,
  parameter int            WR_FWD   = 1,
  parameter logic [DW-1:0] INIT_VAL = '0,
  localparam int           AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  output logic            clr_busy,
  input  logic            rd,
  input  logic [AW-1:0]   raddr,
  output logic            rvalid,
  output logic [DW-1:0]   rdata,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wbe,
  output logic            err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             clr_addr_q, clr_addr_d;
  logic                      err_q, err_d;
  logic [RD_LAT-1:0]         vld_q, vld_d;
  logic [RD_LAT-1:0][DW-1:0] dat_q, dat_d;
  logic [DW-1:0]             mem_q [DEPTH];

  logic          raddr_ok, waddr_ok, rd_acc, we_acc, mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdat, rd_word;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [DW/8-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < DW/8; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  assign raddr_ok = (32'(raddr) < DEPTH);
  assign waddr_ok = (32'(waddr) < DEPTH);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    err_d      = err_q;
    rd_acc     = 1'b0;
    we_acc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_acc = rd;
        we_acc = we & waddr_ok;
        if ((rd & ~raddr_ok) | (we & ~waddr_ok)) err_d = 1'b1;
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        if (rd | we) err_d = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (32'(clr_addr_q) == DEPTH - 1) state_d = ST_IDLE;
      end
    endcase

    // The clear engine owns the write port; user writes only happen in IDLE.
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdat  = INIT_VAL;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
    end else if (we_acc) begin
      mem_we   = 1'b1;
      mem_wdat = merge_bytes(mem_q[waddr], wdata, wbe);
    end
    if (rst) mem_we = 1'b0;

    rd_word = INIT_VAL;
    if (raddr_ok) begin
      rd_word = mem_q[raddr];
      if ((WR_FWD != 0) && we_acc && (waddr == raddr)) rd_word = merge_bytes(rd_word, wdata, wbe);
    end

    // Each stage only loads on a valid beat, so the last stage holds rdata between pulses.
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = rd_acc;
    if (rd_acc) dat_d[0] = rd_word;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
      err_q      <= 1'b0;
      vld_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdat;
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign rvalid   = vld_q[RD_LAT-1];
  assign rdata    = dat_q[RD_LAT-1];
  assign err      = err_q;

endmodule

// File: tb/tb_eva_mem_wrap_p.sv
// Two differently parameterised instances driven with shared stimulus and checked each cycle
// against a queue-based reference model.
module tb_eva_mem_wrap_p;

  logic        clk = 1'b0;
  logic        rst, clr_req, rd, we;
  logic [5:0]  raddr, waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [1:0]        rvalid_o, busy_o, err_o;
  logic [1:0][31:0]  rdata_o;

  always #5 clk = ~clk;

  eva_mem_wrap_p #(.DW(32), .DEPTH(48), .RD_LAT(3), .WR_FWD(1), .INIT_VAL(32'hDEAD_BEEF)) u_dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_o[0]),
    .rd(rd), .raddr(raddr), .rvalid(rvalid_o[0]), .rdata(rdata_o[0]),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe), .err(err_o[0]));

  eva_mem_wrap_p #(.DW(32), .DEPTH(64), .RD_LAT(1), .WR_FWD(0), .INIT_VAL(32'h0)) u_dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_o[1]),
    .rd(rd), .raddr(raddr), .rvalid(rvalid_o[1]), .rdata(rdata_o[1]),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe), .err(err_o[1]));

  typedef struct {
    int          k;
    int          due;
    logic [31:0] dat;
    bit          kn;
  } rd_ent_t;

  rd_ent_t     pend[$];
  int          dep  [2] = '{48, 64};
  int          lat  [2] = '{3, 1};
  int          fwd  [2] = '{1, 0};
  logic [31:0] ival [2] = '{32'hDEAD_BEEF, 32'h0};
  logic [31:0] m     [2][64];
  bit          known [2][64];
  bit          mbusy [2];
  int          cidx  [2];
  bit          merr  [2];
  bit          evld  [2];
  logic [31:0] edat  [2];
  bit          ekn   [2];
  int          busy_cnt [2];
  int          cyc, n_vec, n_err;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input int k);
    int          ra, wa;
    logic [31:0] d;
    bit          kn;
    ra = int'(raddr);
    wa = int'(waddr);
    if (rst) begin
      if (mbusy[k]) known[k][cidx[k]] = 1'b0;
      mbusy[k] = 1'b0;
      merr[k]  = 1'b0;
      edat[k]  = 32'h0;
      ekn[k]   = 1'b1;
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].k == k) pend.delete(i);
    end else if (mbusy[k]) begin
      if (rd || we) merr[k] = 1'b1;
      m[k][cidx[k]]     = ival[k];
      known[k][cidx[k]] = 1'b1;
      cidx[k]++;
      if (cidx[k] == dep[k]) mbusy[k] = 1'b0;
    end else begin
      if (rd) begin
        if (ra < dep[k]) begin
          d  = m[k][ra];
          kn = known[k][ra];
          if (fwd[k] != 0 && we && wa == ra) begin
            d  = merge(d, wdata, wbe);
            kn = kn || (wbe == 4'hF);
          end
        end else begin
          d  = ival[k];
          kn = 1'b1;
          merr[k] = 1'b1;
        end
        pend.push_back('{k, cyc + lat[k], d, kn});
      end
      if (we) begin
        if (wa < dep[k]) begin
          m[k][wa]     = merge(m[k][wa], wdata, wbe);
          known[k][wa] = known[k][wa] || (wbe == 4'hF);
        end else begin
          merr[k] = 1'b1;
        end
      end
      if (clr_req) begin
        mbusy[k] = 1'b1;
        cidx[k]  = 0;
      end
    end
  endtask

  task automatic resolve(input int k);
    int hit;
    hit = -1;
    evld[k] = 1'b0;
    for (int i = 0; i < pend.size(); i++) begin
      if (hit < 0 && pend[i].k == k && pend[i].due == cyc) hit = i;
    end
    if (hit >= 0) begin
      evld[k] = 1'b1;
      edat[k] = pend[hit].dat;
      ekn[k]  = pend[hit].kn;
      pend.delete(hit);
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
    for (int k = 0; k < 2; k++) resolve(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rvalid%0d", k), 32'(rvalid_o[k]), 32'(evld[k]));
      chk($sformatf("clr_busy%0d", k), 32'(busy_o[k]), 32'(mbusy[k]));
      chk($sformatf("err%0d", k), 32'(err_o[k]), 32'(merr[k]));
      if (ekn[k]) chk($sformatf("rdata%0d", k), rdata_o[k], edat[k]);
      if (busy_o[k]) busy_cnt[k]++;
    end
  endtask

  task automatic idle();
    rst = 1'b0; clr_req = 1'b0; rd = 1'b0; we = 1'b0;
  endtask

  task automatic do_wr(input int a, input logic [31:0] d, input logic [3:0] be);
    idle(); we = 1'b1; waddr = 6'(a); wdata = d; wbe = be; tick(); idle();
  endtask

  task automatic do_rd(input int a);
    idle(); rd = 1'b1; raddr = 6'(a); tick(); idle();
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    for (int k = 0; k < 2; k++) begin
      mbusy[k] = 0; merr[k] = 0; evld[k] = 0; edat[k] = 0; ekn[k] = 0; cidx[k] = 0; busy_cnt[k] = 0;
    end
    idle(); raddr = '0; waddr = '0; wdata = '0; wbe = '0;
    rst = 1'b1;
    tick(); tick();
    idle();

    // full clear, then read every address back-to-back
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    clr_req = 1'b1; tick(); idle();
    repeat (70) tick();
    chk("busy_len0", 32'(busy_cnt[0]), 32'd48);
    chk("busy_len1", 32'(busy_cnt[1]), 32'd64);
    for (int a = 0; a < 64; a++) begin
      rd = 1'b1; raddr = 6'(a); tick();
    end
    idle(); repeat (5) tick();
    rst = 1'b1; tick(); idle();

    do_wr(3, 32'hA5A5_5A5A, 4'hF); do_rd(3); repeat (4) tick();
    chk("t1_a", rdata_o[0], 32'hA5A5_5A5A);
    chk("t1_b", rdata_o[1], 32'hA5A5_5A5A);

    do_wr(5, 32'h1122_3344, 4'hF); do_wr(5, 32'hAABB_CCDD, 4'b0101); do_rd(5); repeat (4) tick();
    chk("t2_a", rdata_o[0], 32'h11BB_33DD);
    chk("t2_b", rdata_o[1], 32'h11BB_33DD);

    do_wr(7, 32'h0, 4'hF);
    rd = 1'b1; raddr = 6'd7; we = 1'b1; waddr = 6'd7; wdata = 32'hFFFF_FFFF; wbe = 4'hF; tick(); idle();
    repeat (4) tick();
    chk("t3_fwd", rdata_o[0], 32'hFFFF_FFFF);
    chk("t3_nofwd", rdata_o[1], 32'h0000_0000);

    // user traffic during a clear is ignored and flagged
    clr_req = 1'b1; tick(); idle();
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1; raddr = 6'(i); we = 1'b1; waddr = 6'(i + 10); wdata = 32'h1234_5678; wbe = 4'hF; tick();
    end
    idle();
    chk("clr_err_a", 32'(err_o[0]), 32'd1);
    chk("clr_err_b", 32'(err_o[1]), 32'd1);
    repeat (70) tick();
    for (int a = 0; a < 12; a++) do_rd(a);
    repeat (5) tick();

    for (int i = 0; i < 500; i++) begin
      idle();
      rd      = 1'($urandom_range(0, 1));
      we      = 1'($urandom_range(0, 1));
      raddr   = 6'($urandom_range(0, 63));
      waddr   = ($urandom_range(0, 3) == 0) ? raddr : 6'($urandom_range(0, 63));
      wdata   = $urandom;
      wbe     = 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle(); repeat (70) tick();

    // abort a clear with reset part-way through
    rst = 1'b1; tick(); idle();
    for (int a = 0; a < 64; a++) do_wr(a, ~32'(a), 4'hF);
    rst = 1'b1; tick(); idle();
    clr_req = 1'b1; tick(); idle();
    repeat (9) tick();
    rst = 1'b1; tick(); idle();
    chk("abort_busy_a", 32'(busy_o[0]), 32'd0);
    chk("abort_busy_b", 32'(busy_o[1]), 32'd0);
    chk("abort_rvalid", 32'(rvalid_o), 32'd0);
    for (int a = 0; a < 9; a++) do_rd(a);
    repeat (5) tick();
    do_rd(40); repeat (4) tick();
    chk("t6_40_a", rdata_o[0], ~32'd40);
    chk("t6_40_b", rdata_o[1], ~32'd40);
    do_rd(50); repeat (4) tick();
    chk("t6_oor_a", rdata_o[0], 32'hDEAD_BEEF);
    chk("t6_oor_b", rdata_o[1], ~32'd50);
    chk("t6_err_a", 32'(err_o[0]), 32'd1);
    chk("t6_err_b", 32'(err_o[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
